// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory bank controller.
//   - state_e: controller FSM states (IDLE, CLEAR)
//   - DEF_*:   default geometry used by the interface and the top level
package mem_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_BANDWIDTH  = 8;
    localparam int DEF_ADDR_WIDTH = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/mem_bank_ctrl_if.sv
// mem_bank_ctrl_if: request/response/clear bundle of the memory bank controller.
//   master modport: requester side (drives req_*, clear_req)
//   slave modport:  controller side (drives req_ready, rsp_*, busy, clear_done)
//   Lane i of a word lives at bits [i*DATA_WIDTH +: DATA_WIDTH].
interface mem_bank_ctrl_if
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BANDWIDTH  = DEF_BANDWIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

    localparam int W = DATA_WIDTH * BANDWIDTH;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [W-1:0]          req_wdata;
    logic [BANDWIDTH-1:0]  req_lane_en;
    logic                  rsp_valid;
    logic [W-1:0]          rsp_data;
    logic                  clear_req;
    logic                  busy;
    logic                  clear_done;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_lane_en, clear_req,
        input  req_ready, rsp_valid, rsp_data, busy, clear_done
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_lane_en, clear_req,
        output req_ready, rsp_valid, rsp_data, busy, clear_done
    );

endinterface

// File: rtl/mem_delay_pipe.sv
// mem_delay_pipe: fixed-depth valid+data delay line with synchronous reset.
//   clk_i, rst_i     clock, synchronous active-high reset (flushes every stage)
//   vld_i, data_i    input beat
//   vld_o, data_o    same beat STAGES cycles later (STAGES=0 is a wire)
module mem_delay_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] data_o
);

    if (STAGES == 0) begin : g_pass
        // No storage needed; clock/reset are intentionally unused here.
        logic unused_ok;
        assign unused_ok = clk_i ^ rst_i;
        assign vld_o     = vld_i;
        assign data_o    = data_i;
    end else begin : g_pipe
        logic [STAGES-1:0]            vld_pipe;
        logic [STAGES-1:0][WIDTH-1:0] dat_pipe;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                vld_pipe <= '0;
                dat_pipe <= '0;
            end else begin
                vld_pipe[0] <= vld_i;
                dat_pipe[0] <= data_i;
                for (int s = 1; s < STAGES; s++) begin
                    vld_pipe[s] <= vld_pipe[s-1];
                    dat_pipe[s] <= dat_pipe[s-1];
                end
            end
        end

        assign vld_o  = vld_pipe[STAGES-1];
        assign data_o = dat_pipe[STAGES-1];
    end

endmodule

// File: rtl/mem_bank_ctrl.sv
// mem_bank_ctrl: single-port lane-masked memory bank with zero-fill engine.
//   clk_i   clock, all state on rising edge
//   rst_i   synchronous active-high reset (array contents are not reset)
//   bus     mem_bank_ctrl_if.slave: req_* handshake, rsp_* read return,
//           clear_req / busy / clear_done for the whole-array zero fill
// Reads: the array is sampled into a registered read port at the acceptance
// edge, then delayed READ_LATENCY-1 further cycles by mem_delay_pipe.
module mem_bank_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int BANDWIDTH    = DEF_BANDWIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int READ_LATENCY = 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    mem_bank_ctrl_if.slave bus
);

    localparam int W     = DATA_WIDTH * BANDWIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            rvld_q;

    logic            rd_acc, wr_acc;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [W-1:0]          ram_wdata;
    logic [BANDWIDTH-1:0]  ram_lane_we;

    logic [W-1:0]    ram [DEPTH];
    logic [W-1:0]    rdata_q;
    logic            pipe_vld;
    logic [W-1:0]    pipe_data;

    assign bus.req_ready = (state_q == IDLE) && !bus.clear_req;
    assign wr_acc = bus.req_valid && bus.req_ready &&  bus.req_write;
    assign rd_acc = bus.req_valid && bus.req_ready && !bus.req_write;

    // FSM next state. The counter carries an extra bit so reaching DEPTH is
    // unambiguous; leaving CLEAR schedules the one-cycle done pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q + CW'(1) == CW'(DEPTH)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Single write port shared by the fill engine and accepted writes.
    always_comb begin
        ram_waddr   = bus.req_addr;
        ram_wdata   = bus.req_wdata;
        ram_lane_we = wr_acc ? bus.req_lane_en : '0;
        if (state_q == CLEAR) begin
            ram_waddr   = cnt_q[ADDR_WIDTH-1:0];
            ram_wdata   = '0;
            ram_lane_we = '1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            rvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            rvld_q  <= rd_acc;
        end
    end

    // Storage: no reset, per-lane write enables, registered read.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < BANDWIDTH; i++) begin
            if (ram_lane_we[i])
                ram[ram_waddr][i*DATA_WIDTH +: DATA_WIDTH] <= ram_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
        if (rd_acc)
            rdata_q <= ram[bus.req_addr];
    end

    mem_delay_pipe #(
        .WIDTH  (W),
        .STAGES (READ_LATENCY - 1)
    ) u_pipe (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .vld_i  (rvld_q),
        .data_i (rdata_q),
        .vld_o  (pipe_vld),
        .data_o (pipe_data)
    );

    // rdata_q is unreset block-RAM output, so data is forced to zero off-valid.
    assign bus.rsp_valid  = pipe_vld;
    assign bus.rsp_data   = pipe_vld ? pipe_data : '0;
    assign bus.busy       = (state_q == CLEAR);
    assign bus.clear_done = done_q;

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// tb_mem_bank_ctrl: drives two controllers (READ_LATENCY 1 and 3) with the
// same stimulus and compares both against a cycle-indexed behavioural model.
module tb_mem_bank_ctrl;
    import mem_pkg::*;

    localparam int DW = 32, BW = 8, AW = 6, W = DW * BW, DEPTH = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, v, wr, cr;
    logic [AW-1:0] a;
    logic [W-1:0]  wd;
    logic [BW-1:0] le;

    mem_bank_ctrl_if #(.DATA_WIDTH(DW), .BANDWIDTH(BW), .ADDR_WIDTH(AW)) if1 ();
    mem_bank_ctrl_if #(.DATA_WIDTH(DW), .BANDWIDTH(BW), .ADDR_WIDTH(AW)) if3 ();

    assign if1.req_valid = v;  assign if3.req_valid = v;
    assign if1.req_write = wr; assign if3.req_write = wr;
    assign if1.req_addr  = a;  assign if3.req_addr  = a;
    assign if1.req_wdata = wd; assign if3.req_wdata = wd;
    assign if1.req_lane_en = le; assign if3.req_lane_en = le;
    assign if1.clear_req = cr; assign if3.clear_req = cr;

    mem_bank_ctrl #(.DATA_WIDTH(DW), .BANDWIDTH(BW), .ADDR_WIDTH(AW), .READ_LATENCY(1))
        dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));
    mem_bank_ctrl #(.DATA_WIDTH(DW), .BANDWIDTH(BW), .ADDR_WIDTH(AW), .READ_LATENCY(3))
        dut3 (.clk_i(clk), .rst_i(rst), .bus(if3));

    int n_chk = 0, n_err = 0;
    int cyc = 0;
    bit chk_en = 0;

    // Model: memory image with per-word "known" flag, clear window in cycle
    // numbers, and expected responses keyed by the cycle they must appear in.
    logic [W-1:0] mm [DEPTH];
    bit           kn [DEPTH];
    bit           clr_active = 0;
    int           clr_start = 0;
    int           done_cycle = -1;
    bit           ev1[int], ek1[int], ev3[int], ek3[int];
    logic [W-1:0] ed1[int], ed3[int];

    function automatic bit busy_exp(int c);
        return clr_active && c >= clr_start && c < clr_start + DEPTH;
    endfunction

    function automatic logic [W-1:0] fill(logic [DW-1:0] x);
        return {BW{x}};
    endfunction

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Advance one cycle, applying the effect of the current inputs at the edge.
    task automatic tick();
        bit bz, rdy;
        @(negedge clk); #1;
        if (rst) begin
            if (busy_exp(cyc + 1)) begin
                clr_active = 0;
                for (int i = 0; i < DEPTH; i++) kn[i] = 0;
            end
            if (done_cycle > cyc) done_cycle = -1;
            for (int k = cyc + 1; k <= cyc + 4; k++) begin
                ev1.delete(k); ev3.delete(k);
            end
        end else begin
            bz  = busy_exp(cyc);
            rdy = !bz && !cr;
            if (cr && !bz) begin
                clr_active = 1;
                clr_start  = cyc + 1;
                done_cycle = cyc + 1 + DEPTH;
                for (int i = 0; i < DEPTH; i++) begin mm[i] = '0; kn[i] = 1; end
            end
            if (v && rdy) begin
                if (wr) begin
                    for (int l = 0; l < BW; l++)
                        if (le[l]) mm[a][l*DW +: DW] = wd[l*DW +: DW];
                    if (&le) kn[a] = 1;
                end else begin
                    ev1[cyc+1] = 1; ed1[cyc+1] = mm[a]; ek1[cyc+1] = kn[a];
                    ev3[cyc+3] = 1; ed3[cyc+3] = mm[a]; ek3[cyc+3] = kn[a];
                end
            end
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic peek();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            bit bz;
            bz = busy_exp(cyc);
            chk("ready1", if1.req_ready, !bz && !cr);
            chk("ready3", if3.req_ready, !bz && !cr);
            chk("busy1", if1.busy, bz);
            chk("busy3", if3.busy, bz);
            chk("done1", if1.clear_done, done_cycle == cyc);
            chk("done3", if3.clear_done, done_cycle == cyc);
            if (ev1.exists(cyc)) begin
                chk("rsp1_vld", if1.rsp_valid, 1);
                if (ek1[cyc]) chk("rsp1_data", if1.rsp_data, ed1[cyc]);
            end else begin
                chk("rsp1_vld", if1.rsp_valid, 0);
                chk("rsp1_zero", if1.rsp_data, 0);
            end
            if (ev3.exists(cyc)) begin
                chk("rsp3_vld", if3.rsp_valid, 1);
                if (ek3[cyc]) chk("rsp3_data", if3.rsp_data, ed3[cyc]);
            end else begin
                chk("rsp3_vld", if3.rsp_valid, 0);
                chk("rsp3_zero", if3.rsp_data, 0);
            end
        end
    end

    task automatic rand_phase(int n);
        for (int i = 0; i < n; i++) begin
            v  = ($urandom % 4) != 0;
            wr = $urandom % 2;
            a  = AW'($urandom % DEPTH);
            for (int l = 0; l < BW; l++) wd[l*DW +: DW] = $urandom;
            le = ($urandom % 3 == 0) ? BW'($urandom) : '1;
            cr = ($urandom % 80) == 0;
            tick();
        end
        v = 0; cr = 0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < DEPTH + 4 && busy_exp(cyc); k++) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] lexp;
        int rcyc, bcnt;
        bit got;
        rst = 1; v = 0; wr = 0; cr = 0; a = '0; wd = '0; le = '0;
        for (int i = 0; i < DEPTH; i++) kn[i] = 0;
        tick(); chk_en = 1; tick(); tick();
        rst = 0;
        peek();
        chk("reset_busy", if1.busy, 0);
        chk("reset_done", if3.clear_done, 0);
        chk("reset_rsp", if3.rsp_valid, 0);
        chk("reset_ready", if1.req_ready, 1);

        // Write then read address 5, latency 1.
        v = 1; wr = 1; a = 5; wd = fill(32'h3F800000); le = '1; tick();
        wr = 0; tick(); v = 0; peek();
        chk("lat1_vld", if1.rsp_valid, 1);
        chk("lat1_data", if1.rsp_data, fill(32'h3F800000));

        // Lane-masked overwrite of lane 1 only.
        v = 1; wr = 1; a = 3; wd = fill(32'h1); le = '1; tick();
        wd = fill(32'h7); le = 8'h02; tick();
        wr = 0; tick(); v = 0; peek();
        lexp = fill(32'h1); lexp[63:32] = 32'h7;
        chk("lane_mask", if1.rsp_data, lexp);

        // Latency-3 back-to-back reads.
        for (int i = 0; i < 3; i++) begin
            v = 1; wr = 1; a = AW'(i); wd = fill(32'hA0 + i); le = '1; tick();
        end
        wr = 0;
        a = 0; tick();
        a = 1; tick(); peek(); chk("lat3_early", if3.rsp_valid, 0);
        a = 2; tick(); v = 0;
        for (int i = 0; i < 3; i++) begin
            peek();
            chk("lat3_vld", if3.rsp_valid, 1);
            chk("lat3_data", if3.rsp_data, fill(32'hA0 + i));
            tick();
        end
        peek(); chk("lat3_end", if3.rsp_valid, 0);

        // Read just before clear_req returns pre-clear data; clear window.
        v = 1; wr = 1; a = 9; wd = fill(32'hCAFE0009); le = '1; tick();
        wr = 0; tick(); rcyc = cyc - 1;
        cr = 1; v = 1; a = 5; peek();
        chk("clr_ready_low", if1.req_ready, 0);
        chk("preclr_lat1", if1.rsp_data, fill(32'hCAFE0009));
        tick();
        cr = 0; v = 0; bcnt = 0; got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            peek();
            if (cyc == rcyc + 3) chk("preclr_lat3", if3.rsp_data, fill(32'hCAFE0009));
            if (if1.busy) bcnt++;
            if (if1.clear_done) got = 1;
            else tick();
        end
        chk("clr_done_seen", got, 1);
        chk("clr_busy_cycles", bcnt, 64);
        tick();
        v = 1; wr = 0; a = 5; tick(); v = 0; peek();
        chk("post_clr_vld", if1.rsp_valid, 1);
        chk("post_clr_zero", if1.rsp_data, 0);

        rand_phase(300);
        wait_idle();

        // Reset drops an in-flight latency-3 response.
        v = 1; wr = 0; a = 1; tick();
        v = 0; rst = 1; tick(); rst = 0; tick(); tick(); tick();

        // Reset at clear cycle 10 aborts without a done pulse.
        cr = 1; tick(); cr = 0;
        repeat (10) tick();
        rst = 1; tick(); rst = 0; peek();
        chk("abort_busy", if1.busy, 0);
        chk("abort_done", if1.clear_done, 0);
        chk("abort_rsp", if3.rsp_valid, 0);
        chk("abort_ready", if1.req_ready, 1);
        tick(); tick(); tick();

        cr = 1; tick(); cr = 0;
        wait_idle();
        rand_phase(200);
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_bank_ctrl.md
MEM_BANK_CTRL -- requirements
Module: mem_bank_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, bits per lane element.
REQ-002 Parameter BANDWIDTH, default 8, lanes per memory word; word width W = DATA_WIDTH*BANDWIDTH.
REQ-003 Parameter ADDR_WIDTH, default 6, depth DEPTH = 2**ADDR_WIDTH words.
REQ-004 Parameter READ_LATENCY, default 1, legal range 1..4, cycles from read acceptance to response.
REQ-005 clock  in  1  sole clock, all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  request accepted this cycle when req_valid&req_ready.
REQ-009 req_write  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  ADDR_WIDTH  word address.
REQ-011 req_wdata  in  W  write word, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 req_lane_en  in  BANDWIDTH  per-lane write enable, ignored on reads.
REQ-013 rsp_valid  out  1  read response valid, one-cycle pulse per read.
REQ-014 rsp_data  out  W  read data, zero when rsp_valid=0.
REQ-015 clear_req  in  1  start zero-fill of the whole array.
REQ-016 busy  out  1  high while in CLEAR state.
REQ-017 clear_done  out  1  one-cycle pulse at clear completion.

Function
REQ-018 FSM states IDLE and CLEAR only.
REQ-019 req_ready SHALL equal (state==IDLE) && !clear_req, combinationally.
REQ-020 Accepted write SHALL update only lanes with req_lane_en[i]=1 at req_addr on that clock edge; other lanes hold.
REQ-021 Accepted read SHALL sample the array at acceptance edge and assert rsp_valid with that word exactly READ_LATENCY cycles later.
REQ-022 Back-to-back reads SHALL be accepted every cycle; responses emerge in order, one per cycle, with no backpressure.
REQ-023 Read accepted the cycle after a write to the same address SHALL return the written data.
REQ-024 IDLE with clear_req=1 -> CLEAR next cycle, clear counter = 0; busy=1 from that cycle.
REQ-025 In CLEAR, the controller SHALL write all-zero word to counter address each cycle, counter +1, for exactly DEPTH cycles.
REQ-026 After the write to address DEPTH-1, state SHALL return to IDLE and clear_done SHALL pulse in that first IDLE cycle.
REQ-027 clear_req during CLEAR SHALL be ignored (no restart, no extension).
REQ-028 Reads accepted before CLEAR entry SHALL complete normally with pre-clear data.
REQ-029 Counter SHALL be ADDR_WIDTH+1 bits so DEPTH terminates without wrap ambiguity.

Reset
REQ-030 On reset: state=IDLE, counter=0, busy=0, clear_done=0, rsp_valid=0, rsp_data=0, latency pipe flushed.
REQ-031 Reset SHALL NOT initialise array contents; contents undefined until written or cleared.
REQ-032 Reset asserted mid-CLEAR SHALL abort the fill with no clear_done pulse; partial zeroing is permitted.
REQ-033 Reset SHALL drop all in-flight read responses.

Structure
REQ-034 Shared package mem_pkg SHALL hold the state enum (IDLE, CLEAR) and default DATA_WIDTH/BANDWIDTH/ADDR_WIDTH constants.
REQ-035 The response delay line SHALL be sub-module mem_delay_pipe (parametrised width and depth, valid+data, sync reset).
REQ-036 The array SHALL be inferable as block RAM: single write port, registered read port, no reset on storage.

Verification
REQ-037 Reset, write addr 5 all lanes 0x3F800000, read addr 5 (LAT=1) -> rsp_valid one cycle after acceptance, every lane 0x3F800000.
REQ-038 Write addr 3 all 0x1, then write addr 3 lane_en=0x02 data all 0x7 -> read returns lane1=0x7, other lanes 0x1.
REQ-039 LAT=3, reads addr 0,1,2 on consecutive cycles -> three consecutive rsp_valid pulses starting 3 cycles after first acceptance, data in order.
REQ-040 clear_req with req_valid same cycle in IDLE -> req_ready=0, busy for 64 cycles (defaults), clear_done pulse, subsequent read of any address returns 0.
REQ-041 Reset asserted at CLEAR cycle 10 -> IDLE next cycle, busy=0, no clear_done, rsp_valid=0, req_ready=1.
REQ-042 Read issued the cycle before clear_req -> response carries pre-clear data.
